jzjpcc_ct_redirect: RTL and testbench

//  Execute-stage control-transfer resolver; drives the fetch PC's redirect inputs.
//  - Evaluates branch conditions and computes targets for JAL, JALR and branch instructions in execute.
//  - Drives pcCTWriteEnable / controlTransferNewPC, and holds a redirect until a stalled fetch accepts it.
//  - Squashes wrong-path fetch/decode instructions and supplies the link value (pc+4) for rd.

---
 rtl/jzjpcc_ct_redirect_pkg.sv | 11 +
 rtl/jzjpcc_ct_redirect_if.sv | 29 ++
 rtl/jzjpcc_ct_redirect_branch_compare.sv | 22 ++
 rtl/jzjpcc_ct_redirect.sv | 52 +++++
 tb/tb_jzjpcc_ct_redirect.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/jzjpcc_ct_redirect_pkg.sv
// jzjpcc_ct_redirect_pkg: shared types and branch condition codes for the execute-stage CT resolver.
package jzjpcc_ct_redirect_pkg;
  typedef enum logic [1:0] {CT_NONE, CT_BRANCH, CT_JAL, CT_JALR} ct_type_t;
  typedef enum logic {IDLE, PENDING} redirect_state_t;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;
endpackage

// File: rtl/jzjpcc_ct_redirect_if.sv
// jzjpcc_ct_redirect_if: execute-stage operands in, PC redirect/squash/link signals out.
interface jzjpcc_ct_redirect_if #(parameter int PC_MAX_B = 15);
  import jzjpcc_ct_redirect_pkg::*;
  ct_type_t            ctType_execute;
  logic [2:0]          funct3_execute;
  logic                stall_execute;
  logic                stall_fetch;
  logic [PC_MAX_B:2]   pc_execute;
  logic [31:0]         rs1_execute;
  logic [31:0]         rs2_execute;
  logic [31:0]         imm_execute;
  logic                pcCTWriteEnable;
  logic [PC_MAX_B:2]   controlTransferNewPC;
  logic                flush_fetchDecode;
  logic [31:0]         linkValue_execute;
  logic                misalignedCT_execute;
  modport master (
    output ctType_execute, funct3_execute, stall_execute, stall_fetch,
    output pc_execute, rs1_execute, rs2_execute, imm_execute,
    input  pcCTWriteEnable, controlTransferNewPC, flush_fetchDecode,
    input  linkValue_execute, misalignedCT_execute
  );
  modport slave (
    input  ctType_execute, funct3_execute, stall_execute, stall_fetch,
    input  pc_execute, rs1_execute, rs2_execute, imm_execute,
    output pcCTWriteEnable, controlTransferNewPC, flush_fetchDecode,
    output linkValue_execute, misalignedCT_execute
  );
endinterface

// File: rtl/jzjpcc_ct_redirect_branch_compare.sv
// jzjpcc_branch_compare: combinational branch condition evaluation; unused funct3 codes never take.
module jzjpcc_branch_compare
  import jzjpcc_ct_redirect_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  output logic        taken
);
  logic eq, lt, ltu;
  always_comb begin
    eq  = rs1 == rs2;
    lt  = $signed(rs1) < $signed(rs2);
    ltu = rs1 < rs2;
    taken = funct3 == FUNCT3_BEQ  ? eq   :
            funct3 == FUNCT3_BNE  ? !eq  :
            funct3 == FUNCT3_BLT  ? lt   :
            funct3 == FUNCT3_BGE  ? !lt  :
            funct3 == FUNCT3_BLTU ? ltu  :
            funct3 == FUNCT3_BGEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/jzjpcc_ct_redirect.sv
// jzjpcc_ct_redirect: resolves JAL/JALR/branches in execute and drives the fetch PC redirect,
// holding the redirect while fetch is stalled.
module jzjpcc_ct_redirect
  import jzjpcc_ct_redirect_pkg::*;
#(
  parameter int PC_MAX_B = 15
) (
  input logic                 clock,
  input logic                 reset,
  jzjpcc_ct_redirect_if.slave ct
);
  redirect_state_t   state, state_next;
  logic [PC_MAX_B:2] pending_target;
  logic [PC_MAX_B:1] target;
  logic              cond, taken, res, issue;
  jzjpcc_branch_compare u_cmp (
    .rs1    (ct.rs1_execute),
    .rs2    (ct.rs2_execute),
    .funct3 (ct.funct3_execute),
    .taken  (cond)
  );
  // Only bits [PC_MAX_B:1] of the 32-bit target matter: the rest wrap away, bit 0 is JALR-cleared.
  always_comb begin
    target = ct.ctType_execute == CT_JALR ?
             PC_MAX_B'((ct.rs1_execute + ct.imm_execute) >> 1) :
             PC_MAX_B'((32'({ct.pc_execute, 2'b00}) + ct.imm_execute) >> 1);
    taken  = ct.ctType_execute == CT_BRANCH ? cond : ct.ctType_execute != CT_NONE;
    res    = ct.ctType_execute != CT_NONE && !ct.stall_execute && state == IDLE;
    issue  = res && taken && !target[1];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pending_target <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && issue && ct.stall_fetch) pending_target <= target[PC_MAX_B:2];
    end
  end
  always_comb begin
    state_next = state == PENDING ? (ct.stall_fetch ? PENDING : IDLE) :
                 (issue && ct.stall_fetch ? PENDING : IDLE);
  end
  always_comb begin
    ct.pcCTWriteEnable      = state == PENDING || issue;
    ct.flush_fetchDecode    = state == PENDING || issue;
    ct.controlTransferNewPC = state == PENDING ? pending_target :
                              issue ? target[PC_MAX_B:2] : '0;
    ct.misalignedCT_execute = res && taken && target[1];
    ct.linkValue_execute    = 32'({ct.pc_execute, 2'b00}) + 32'd4;
  end
endmodule

// File: tb/tb_jzjpcc_ct_redirect.sv
// tb_jzjpcc_ct_redirect: directed + random stimulus checked every cycle against a behavioural model.
module tb_jzjpcc_ct_redirect;
  import jzjpcc_ct_redirect_pkg::*;
  localparam int PC_MAX_B = 15;
  logic clock = 0;
  logic reset = 1;
  int   n_checks = 0;
  int   n_fail = 0;
  jzjpcc_ct_redirect_if #(.PC_MAX_B(PC_MAX_B)) bus ();
  jzjpcc_ct_redirect #(.PC_MAX_B(PC_MAX_B)) dut (.clock(clock), .reset(reset), .ct(bus));
  always #5 clock = ~clock;
  bit                m_pend = 0;
  logic [PC_MAX_B:2] m_tgt = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 0;
    endcase
  endfunction
  function automatic logic [31:0] byte_target();
    logic [31:0] pcb;
    pcb = 0;
    pcb[PC_MAX_B:2] = bus.pc_execute;
    if (bus.ctType_execute == CT_JALR) return (bus.rs1_execute + bus.imm_execute) & 32'hFFFF_FFFE;
    return pcb + bus.imm_execute;
  endfunction
  function automatic bit resolved_taken();
    if (bus.ctType_execute == CT_NONE || bus.stall_execute || m_pend) return 0;
    if (bus.ctType_execute == CT_BRANCH) return cond_taken(bus.funct3_execute, bus.rs1_execute, bus.rs2_execute);
    return 1;
  endfunction
  always @(posedge clock or posedge reset) begin
    logic [31:0] t;
    if (reset) begin
      m_pend = 0;
      m_tgt = '0;
    end else if (m_pend) begin
      if (!bus.stall_fetch) m_pend = 0;
    end else begin
      t = byte_target();
      if (resolved_taken() && !t[1] && bus.stall_fetch) begin
        m_pend = 1;
        m_tgt = t[PC_MAX_B:2];
      end
    end
  end
  always @(negedge clock) begin
    logic [31:0] t, link;
    bit tk, iss, we;
    logic [PC_MAX_B:2] npc;
    t = byte_target();
    tk = resolved_taken();
    iss = tk && !t[1];
    we = m_pend || iss;
    npc = m_pend ? m_tgt : iss ? t[PC_MAX_B:2] : '0;
    link = 0;
    link[PC_MAX_B:2] = bus.pc_execute;
    link = link + 4;
    chk("model_we", 32'(bus.pcCTWriteEnable), 32'(we));
    chk("model_flush", 32'(bus.flush_fetchDecode), 32'(we));
    chk("model_newpc", 32'(bus.controlTransferNewPC), 32'(npc));
    chk("model_misaligned", 32'(bus.misalignedCT_execute), 32'(tk && t[1]));
    chk("model_link", bus.linkValue_execute, link);
  end
  task automatic drive(input ct_type_t c, input logic [2:0] f3, input bit se, input bit sf,
                       input logic [PC_MAX_B:2] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    @(posedge clock);
    #1;
    bus.ctType_execute = c;
    bus.funct3_execute = f3;
    bus.stall_execute = se;
    bus.stall_fetch = sf;
    bus.pc_execute = pc;
    bus.rs1_execute = a;
    bus.rs2_execute = b;
    bus.imm_execute = imm;
  endtask
  task automatic expect_out(input string name, input bit we, input logic [31:0] npc);
    @(negedge clock);
    chk({name, "_we"}, 32'(bus.pcCTWriteEnable), 32'(we));
    chk({name, "_flush"}, 32'(bus.flush_fetchDecode), 32'(we));
    chk({name, "_newpc"}, 32'(bus.controlTransferNewPC), npc);
  endtask
  initial begin
    bus.ctType_execute = CT_NONE;
    bus.funct3_execute = 0;
    bus.stall_execute = 0;
    bus.stall_fetch = 0;
    bus.pc_execute = 0;
    bus.rs1_execute = 0;
    bus.rs2_execute = 0;
    bus.imm_execute = 0;
    expect_out("reset", 0, 0);
    @(posedge clock);
    #1 reset = 0;
    drive(CT_BRANCH, 3'b000, 0, 0, 14'h40, 5, 5, 32'h40);
    expect_out("beq_taken", 1, 32'h50);
    drive(CT_NONE, 3'b000, 0, 0, 14'h40, 5, 5, 32'h40);
    expect_out("beq_one_cycle", 0, 0);
    drive(CT_BRANCH, 3'b001, 0, 0, 14'h40, 5, 5, 32'h40);
    expect_out("bne_equal", 0, 0);
    drive(CT_BRANCH, 3'b010, 0, 0, 14'h40, 5, 6, 32'h40);
    expect_out("funct3_010", 0, 0);
    drive(CT_BRANCH, 3'b100, 0, 0, 14'h0, 32'hFFFF_FFFF, 1, 32'h8);
    expect_out("blt_signed", 1, 32'h2);
    drive(CT_BRANCH, 3'b110, 0, 0, 14'h0, 32'hFFFF_FFFF, 1, 32'h8);
    expect_out("bltu_unsigned", 0, 0);
    drive(CT_JALR, 3'b000, 0, 1, 14'h0, 32'h203, 0, 32'h1);
    expect_out("jalr_issue", 1, 32'h81);
    for (int i = 0; i < 2; i++) begin
      drive(CT_JAL, 3'b000, 0, 1, 14'h0, 0, 0, 32'h100);
      expect_out("jalr_hold", 1, 32'h81);
    end
    drive(CT_JAL, 3'b000, 0, 0, 14'h0, 0, 0, 32'h100);
    expect_out("jalr_last", 1, 32'h81);
    drive(CT_JAL, 3'b000, 0, 0, 14'h0, 0, 0, 32'h100);
    expect_out("after_pending", 1, 32'h40);
    drive(CT_JAL, 3'b000, 0, 0, 14'h4, 0, 0, 32'h6);
    @(negedge clock);
    chk("jal_misaligned", 32'(bus.misalignedCT_execute), 1);
    chk("jal_mis_we", 32'(bus.pcCTWriteEnable), 0);
    chk("jal_link", bus.linkValue_execute, 32'h14);
    drive(CT_JALR, 3'b000, 0, 1, 14'h0, 32'h300, 0, 32'h0);
    drive(CT_NONE, 3'b000, 0, 1, 14'h0, 0, 0, 0);
    #2 reset = 1;
    #1 chk("reset_async_we", 32'(bus.pcCTWriteEnable), 0);
    @(posedge clock);
    #1 reset = 0;
    drive(CT_NONE, 3'b000, 0, 0, 14'h0, 0, 0, 0);
    expect_out("no_redirect_after_reset", 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = $urandom_range(0, 3) == 0 ? 32'h8000_0000 - $urandom_range(0, 2) : $urandom_range(0, 6);
      b = $urandom_range(0, 2) == 0 ? a : $urandom();
      drive(ct_type_t'($urandom_range(0, 3)), 3'($urandom()), $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, 14'($urandom()), a, b, $urandom() & 32'h0000_FFFE);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1;
        #1 reset = 0;
      end
    end
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
